// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants for the KLP32 multi-cycle control sequencer.
//   - RV32I opcode constants used by the sequencer and the ALU-op decoder
//   - ALU operation codes driven onto alu_op
//   - state encodings (FETCH .. TRAP) exposed on the debug state port
//   - pc_sel / wb_sel / A_select codes
//   - ctrl_t: bundle of datapath control strobes built per state
package multicycle_ctrl_fsm_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [1:0] PC_SEL_PC4  = 2'b00;
    localparam logic [1:0] PC_SEL_IMM  = 2'b01;
    localparam logic [1:0] PC_SEL_JALR = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [1:0] A_SEL_RS1  = 2'b00;
    localparam logic [1:0] A_SEL_PC   = 2'b01;
    localparam logic [1:0] A_SEL_ZERO = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       instr_fetch;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic [1:0] a_select;
        logic       b_select;
        logic [3:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = ctrl_t'({$bits(ctrl_t){1'b0}});

    // True for every opcode the sequencer knows how to step through.
    function automatic logic opcode_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_op_decoder.sv
// alu_op_decoder: combinational map from instruction fields to ALU operation.
//   opcode    in  7  instr[6:0]
//   funct3    in  3  instr[14:12]
//   funct7_b5 in  1  instr[30]; selects SUB for R-type and SRA/SRAI for shifts
//   alu_op    out 4  ALU operation code
// Anything that only needs an address or sum (loads, stores, jumps, LUI,
// AUIPC, unknown opcodes) falls through to ADD.
module alu_op_decoder
    import multicycle_ctrl_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_op
);

    // Decode funct3/funct7_b5 per instruction class.
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_R, OP_I_ALU: begin
                case (funct3)
                    3'b000: begin
                        // Immediate forms have no SUBI; instr[30] is immediate data there.
                        if ((opcode == OP_R) && funct7_b5) begin
                            alu_op = ALU_SUB;
                        end else begin
                            alu_op = ALU_ADD;
                        end
                    end
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: begin
                        if (funct7_b5) begin
                            alu_op = ALU_SRA;
                        end else begin
                            alu_op = ALU_SRL;
                        end
                    end
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer for the KLP32
// RV32I multi-cycle datapath (one ALU, one memory port).
//   clk, rst_n                 clock, synchronous active-low reset
//   opcode/funct3/funct7_b5    fields from the instruction register
//   branch_taken, mem_ready    comparator result (EXEC) / memory handshake
//   mem_req, mem_we, instr_fetch, ir_write, pc_write, pc_sel,
//   A_select, B_select, alu_op, reg_write, wb_sel   datapath controls
//   illegal_instr, bus_err     sticky fault flags (cleared only by reset)
//   state                      current state for debug
// Controls are combinational from the registered state so that handshake
// responses (ir_write, pc_write on mem_ready) land in the same cycle.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       instr_fetch,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic [1:0] A_select,
    output logic       B_select,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       illegal_instr,
    output logic       bus_err,
    output logic [2:0] state
);

    logic [2:0]       state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             illegal_r;
    logic             bus_err_r;

    logic [2:0]       state_next_s;
    logic [CNT_W-1:0] wait_cnt_next_s;
    logic             illegal_set_s;
    logic             bus_err_set_s;
    logic [3:0]       dec_alu_op_s;
    logic             wait_expired_s;
    ctrl_t            ctrl_s;

    alu_op_decoder u_alu_op_decoder (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .alu_op    (dec_alu_op_s)
    );

    // This cycle would be the WAIT_LIMIT-th unanswered request cycle.
    assign wait_expired_s = (wait_cnt_r == CNT_W'(WAIT_LIMIT - 1));

    // Next-state, wait-counter and control-strobe generation.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = {CNT_W{1'b0}};
        illegal_set_s   = 1'b0;
        bus_err_set_s   = 1'b0;
        ctrl_s          = CTRL_IDLE;
        ctrl_s.alu_op   = ALU_ADD;
        case (state_r)
            ST_FETCH: begin
                ctrl_s.mem_req     = 1'b1;
                ctrl_s.instr_fetch = 1'b1;
                // A ready on the final allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    ctrl_s.ir_write = 1'b1;
                    state_next_s    = ST_DECODE;
                end else if (wait_expired_s) begin
                    bus_err_set_s = 1'b1;
                    state_next_s  = ST_TRAP;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (opcode_supported(opcode)) begin
                    state_next_s = ST_EXEC;
                end else begin
                    illegal_set_s = 1'b1;
                    state_next_s  = ST_TRAP;
                end
            end
            ST_EXEC: begin
                ctrl_s.alu_op = dec_alu_op_s;
                case (opcode)
                    OP_R: begin
                        ctrl_s.a_select = A_SEL_RS1;
                        ctrl_s.b_select = 1'b0;
                        state_next_s    = ST_WB;
                    end
                    OP_I_ALU, OP_JALR: begin
                        ctrl_s.a_select = A_SEL_RS1;
                        ctrl_s.b_select = 1'b1;
                        state_next_s    = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        ctrl_s.a_select = A_SEL_RS1;
                        ctrl_s.b_select = 1'b1;
                        state_next_s    = ST_MEM;
                    end
                    OP_LUI: begin
                        ctrl_s.a_select = A_SEL_ZERO;
                        ctrl_s.b_select = 1'b1;
                        state_next_s    = ST_WB;
                    end
                    OP_AUIPC: begin
                        ctrl_s.a_select = A_SEL_PC;
                        ctrl_s.b_select = 1'b1;
                        state_next_s    = ST_WB;
                    end
                    OP_BRANCH: begin
                        // Branches retire here: the PC update is their only effect.
                        ctrl_s.a_select = A_SEL_RS1;
                        ctrl_s.b_select = 1'b0;
                        ctrl_s.pc_write = 1'b1;
                        if (branch_taken) begin
                            ctrl_s.pc_sel = PC_SEL_IMM;
                        end else begin
                            ctrl_s.pc_sel = PC_SEL_PC4;
                        end
                        state_next_s = ST_FETCH;
                    end
                    OP_JAL: begin
                        ctrl_s.a_select = A_SEL_RS1;
                        ctrl_s.b_select = 1'b0;
                        state_next_s    = ST_WB;
                    end
                    default: begin
                        // Opcode changed under us after DECODE; refuse to continue.
                        illegal_set_s = 1'b1;
                        state_next_s  = ST_TRAP;
                    end
                endcase
            end
            ST_MEM: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.mem_we  = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        ctrl_s.pc_write = 1'b1;
                        ctrl_s.pc_sel   = PC_SEL_PC4;
                        state_next_s    = ST_FETCH;
                    end else begin
                        state_next_s = ST_WB;
                    end
                end else if (wait_expired_s) begin
                    bus_err_set_s = 1'b1;
                    state_next_s  = ST_TRAP;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
                end
            end
            ST_WB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.pc_write  = 1'b1;
                case (opcode)
                    OP_LOAD: begin
                        ctrl_s.wb_sel = WB_SEL_MEM;
                        ctrl_s.pc_sel = PC_SEL_PC4;
                    end
                    OP_JAL: begin
                        ctrl_s.wb_sel = WB_SEL_PC4;
                        ctrl_s.pc_sel = PC_SEL_IMM;
                    end
                    OP_JALR: begin
                        ctrl_s.wb_sel = WB_SEL_PC4;
                        ctrl_s.pc_sel = PC_SEL_JALR;
                    end
                    default: begin
                        ctrl_s.wb_sel = WB_SEL_ALU;
                        ctrl_s.pc_sel = PC_SEL_PC4;
                    end
                endcase
                state_next_s = ST_FETCH;
            end
            ST_TRAP: begin
                state_next_s = ST_TRAP;
            end
            default: begin
                // Unused encodings are treated as a fault and parked in TRAP.
                state_next_s = ST_TRAP;
            end
        endcase
    end

    // State register, wait counter and sticky fault flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            wait_cnt_r <= {CNT_W{1'b0}};
            illegal_r  <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            illegal_r  <= illegal_r | illegal_set_s;
            bus_err_r  <= bus_err_r | bus_err_set_s;
        end
    end

    // Output drive; everything is forced low while reset is asserted so an
    // in-flight memory request drops in the reset cycle itself.
    always_comb begin
        if (!rst_n) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            instr_fetch   = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_sel        = 2'b00;
            A_select      = 2'b00;
            B_select      = 1'b0;
            alu_op        = 4'd0;
            reg_write     = 1'b0;
            wb_sel        = 2'b00;
            illegal_instr = 1'b0;
            bus_err       = 1'b0;
            state         = 3'd0;
        end else begin
            mem_req       = ctrl_s.mem_req;
            mem_we        = ctrl_s.mem_we;
            instr_fetch   = ctrl_s.instr_fetch;
            ir_write      = ctrl_s.ir_write;
            pc_write      = ctrl_s.pc_write;
            pc_sel        = ctrl_s.pc_sel;
            A_select      = ctrl_s.a_select;
            B_select      = ctrl_s.b_select;
            alu_op        = ctrl_s.alu_op;
            reg_write     = ctrl_s.reg_write;
            wb_sel        = ctrl_s.wb_sel;
            illegal_instr = illegal_r;
            bus_err       = bus_err_r;
            state         = state_r;
        end
    end

endmodule
